cdr_shift_commander: RTL and testbench
======================================

Name: cdr_shift_commander

Overview:
- Phase-decision front end of the PRN CDR loop. It produces the sr/sl shift commands that the delay line controller consumes.
- Each cycle it takes an early sample and a data sample from the delay-line taps and forms a bang-bang phase decision on every data transition.
- Decisions are integrated in a saturating vote counter. When the count crosses a threshold, the block issues a single-cycle sr or sl pulse.
- After each pulse it holds off while the delay line settles. It also tracks the commanded tap position so it never drives the line past either end.

Parameters:
- VOTE_W, 5: width of the signed vote accumulator.
- THRESH, 8: vote magnitude that triggers a shift. Must satisfy 1 <= THRESH <= 2^(VOTE_W-1)-1.
- HOLDOFF, 4: idle cycles after each shift pulse before voting resumes. Must be >= 1.
- TAPS, 32: number of delay-line taps.
- POS_W, 5: tap position width, equal to clog2(TAPS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  loop enable. While 0, state is frozen and no pulses are issued.
- din_e  in  1  early (edge) sample from the delay line.
- din_d  in  1  data (centre) sample from the delay line.
- din_valid  in  1  the sample pair is valid this cycle.
- sr  out  1  shift-right command, single-cycle pulse.
- sl  out  1  shift-left command, single-cycle pulse.
- tap_pos  out  POS_W  commanded tap index.
- at_limit  out  1  tap_pos is 0 or TAPS-1.

Behaviour:
- Reset values: sr=0, sl=0, tap_pos=TAPS/2, at_limit=0, vote=0, d_prev=0, state=WARM, hold counter=0.
- Phase detection applies only when en=1 and din_valid=1.
  - Transition: din_d != d_prev.
  - late = transition and (din_e == din_d).
  - early = transition and (din_e == d_prev).
  - d_prev <= din_d on every valid cycle.
- States:
  - WARM: first valid cycle only loads d_prev, with no vote. Then go to TRACK.
  - TRACK: early adds +1 to vote, late adds -1. Vote saturates at ±(2^(VOTE_W-1)-1).
    - Vote >= THRESH: registered sr=1 on the next cycle, tap_pos+1, vote cleared, go to HOLD.
    - Vote <= -THRESH: sl=1, tap_pos-1, vote cleared, go to HOLD.
  - HOLD: counts HOLDOFF cycles regardless of din_valid. Samples are ignored and d_prev is still updated. Then return to TRACK.
- Latency: a pulse appears exactly one clock after the valid cycle whose vote reaches the threshold.
- Pulse shape: sr and sl are never both 1 and are never asserted for two consecutive cycles.
- Limits:
  - If tap_pos=TAPS-1, an sr request is suppressed. Vote is cleared, tap_pos is unchanged, and the block goes to HOLD.
  - If tap_pos=0, sl is suppressed the same way.
  - at_limit is combinational from tap_pos.
- en=0: all registers hold and sr=sl=0. Deasserting en during HOLD freezes the hold counter.
- Reset mid-operation returns to the reset values immediately, including aborting any pending pulse.

Optional Feature:
- Macro: CDR_LOCK_DETECT_EN.
- When defined: adds output lock (1 bit, reset 0) and parameter LOCK_CNT (default 64).
  - A counter increments on every valid TRACK transition cycle that causes no shift.
  - lock asserts when the counter reaches LOCK_CNT and holds at saturation.
  - Any sr/sl pulse, or any suppressed request at a limit, clears the counter and lock.
- When undefined: no lock port and no counter logic.

Decomposition:
- Shared package cdr_pkg holds:
  - state enum: WARM, TRACK, HOLD;
  - default constants: VOTE_W, THRESH, HOLDOFF, TAPS;
  - the clog2-based POS_W helper.
- One natural sub-module: cdr_vote_integrator. It contains the saturating signed up/down counter with synchronous clear and threshold compare outputs.

Test Plan:
- Reset release, then alternating din_d 0/1 with din_e=d_prev on each valid cycle → after WARM, 8 early votes, sr pulses one cycle after the 8th, tap_pos 16→17, then 4 HOLD cycles with no pulse.
- Same pattern with din_e=din_d → sl pulse after 8 late votes, tap_pos 16→15.
- Mixed early/late (+1,-1 repeating) for 100 cycles → no sr/sl, tap_pos stays 16.
- Continuous early drive from tap 16 → 15 sr pulses reach tap_pos=31 with at_limit=1. Further requests produce no sr and tap_pos stays 31.
- Assert rst=0 in the cycle the vote hits threshold → no pulse, tap_pos=16, and the following valid cycle is WARM.
- Under CDR_LOCK_DETECT_EN with balanced votes and 64 transition cycles → lock=1. A forced sr pulse then clears lock on the next cycle.

Source files
------------

// File: rtl/cdr_pkg.sv
// Shared types and defaults for the CDR shift commander slice.
package cdr_pkg;

    typedef enum logic [1:0] {
        WARM  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } cdr_state_e;

    localparam int unsigned VOTE_W_DEF  = 5;
    localparam int unsigned THRESH_DEF  = 8;
    localparam int unsigned HOLDOFF_DEF = 4;
    localparam int unsigned TAPS_DEF    = 32;

    // Width needed to index n values; never narrower than one bit.
    function automatic int unsigned pos_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cdr_vote_integrator.sv
// Saturating signed up/down vote counter with synchronous clear.
// Threshold flags look at the post-vote value so the caller can act
// in the same cycle the vote lands.
module cdr_vote_integrator
    import cdr_pkg::*;
#(
    parameter int unsigned VOTE_W = VOTE_W_DEF,
    parameter int unsigned THRESH = THRESH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up,
    input  logic                     dn,
    input  logic                     clr,
    output logic signed [VOTE_W-1:0] vote,
    output logic                     hit_pos,
    output logic                     hit_neg
);

    localparam logic signed [VOTE_W-1:0] VMAX = VOTE_W'((1 << (VOTE_W - 1)) - 1);
    localparam logic signed [VOTE_W-1:0] VMIN = -VMAX;
    localparam logic signed [VOTE_W-1:0] TH   = VOTE_W'(THRESH);
    localparam logic signed [VOTE_W-1:0] NTH  = -TH;

    logic signed [VOTE_W-1:0] vote_q, vote_d, sum;

    // Saturating step, threshold compare on the stepped value, then clear.
    always_comb begin
        sum = vote_q;
        if (up && !dn && vote_q != VMAX) begin
            sum = vote_q + VOTE_W'(1);
        end else if (dn && !up && vote_q != VMIN) begin
            sum = vote_q - VOTE_W'(1);
        end
        hit_pos = (sum >= TH);
        hit_neg = (sum <= NTH);
        vote_d  = clr ? '0 : sum;
    end

    // Vote register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vote_q <= '0;
        end else begin
            vote_q <= vote_d;
        end
    end

    assign vote = vote_q;

endmodule

// File: rtl/cdr_shift_commander.sv
// Bang-bang phase detector + vote integrator issuing sr/sl shift pulses
// to the delay line, with post-shift holdoff and tap-range tracking.
// Optional lock detector enabled by defining CDR_LOCK_DETECT_EN.
module cdr_shift_commander
    import cdr_pkg::*;
#(
    parameter int unsigned VOTE_W  = VOTE_W_DEF,
    parameter int unsigned THRESH  = THRESH_DEF,
    parameter int unsigned HOLDOFF = HOLDOFF_DEF,
    parameter int unsigned TAPS    = TAPS_DEF,
    parameter int unsigned POS_W   = pos_w(TAPS)
`ifdef CDR_LOCK_DETECT_EN
    ,
    parameter int unsigned LOCK_CNT = 64
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din_e,
    input  logic             din_d,
    input  logic             din_valid,
    output logic             sr,
    output logic             sl,
    output logic [POS_W-1:0] tap_pos,
`ifdef CDR_LOCK_DETECT_EN
    output logic             lock,
`endif
    output logic             at_limit
);

    localparam int unsigned         HOLD_W    = pos_w(HOLDOFF);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [POS_W-1:0]    TAP_TOP   = POS_W'(TAPS - 1);
    localparam logic [POS_W-1:0]    TAP_MID   = POS_W'(TAPS / 2);

    cdr_state_e          state_q, state_d;
    logic                d_prev_q, d_prev_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [POS_W-1:0]    tap_q, tap_d;
    logic                sr_q, sr_d, sl_q, sl_d;
    logic                transition, early, late;
    logic                v_up, v_dn, v_clr, hit_pos, hit_neg;
    logic signed [VOTE_W-1:0] vote;

    cdr_vote_integrator #(
        .VOTE_W (VOTE_W),
        .THRESH (THRESH)
    ) u_vote (
        .clk     (clk),
        .rst     (rst),
        .up      (v_up),
        .dn      (v_dn),
        .clr     (v_clr),
        .vote    (vote),
        .hit_pos (hit_pos),
        .hit_neg (hit_neg)
    );

    // Phase decision and next-state / shift-command logic.
    always_comb begin
        state_d  = state_q;
        d_prev_d = d_prev_q;
        hold_d   = hold_q;
        tap_d    = tap_q;
        sr_d     = 1'b0;
        sl_d     = 1'b0;
        v_up     = 1'b0;
        v_dn     = 1'b0;
        v_clr    = 1'b0;

        transition = (din_d != d_prev_q);
        early      = transition && (din_e == d_prev_q);
        late       = transition && (din_e == din_d);

        if (en) begin
            case (state_q)
                WARM: begin
                    if (din_valid) begin
                        d_prev_d = din_d;
                        state_d  = TRACK;
                    end
                end
                TRACK: begin
                    if (din_valid) begin
                        d_prev_d = din_d;
                        v_up     = early;
                        v_dn     = late;
                        // A request at a tap limit still clears the vote and
                        // takes the holdoff; only the pulse is withheld.
                        if ((early && hit_pos) || (late && hit_neg)) begin
                            v_clr   = 1'b1;
                            hold_d  = '0;
                            state_d = HOLD;
                            if (early && tap_q != TAP_TOP) begin
                                sr_d  = 1'b1;
                                tap_d = tap_q + POS_W'(1);
                            end else if (late && tap_q != '0) begin
                                sl_d  = 1'b1;
                                tap_d = tap_q - POS_W'(1);
                            end
                        end
                    end
                end
                HOLD: begin
                    if (din_valid) begin
                        d_prev_d = din_d;
                    end
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = TRACK;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: state_d = WARM;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= WARM;
            d_prev_q <= 1'b0;
            hold_q   <= '0;
            tap_q    <= TAP_MID;
            sr_q     <= 1'b0;
            sl_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            d_prev_q <= d_prev_d;
            hold_q   <= hold_d;
            tap_q    <= tap_d;
            sr_q     <= sr_d;
            sl_q     <= sl_d;
        end
    end

    assign sr       = sr_q;
    assign sl       = sl_q;
    assign tap_pos  = tap_q;
    assign at_limit = (tap_q == '0) || (tap_q == TAP_TOP);

`ifdef CDR_LOCK_DETECT_EN
    localparam int unsigned      LK_W   = pos_w(LOCK_CNT + 1);
    localparam logic [LK_W-1:0]  LK_MAX = LK_W'(LOCK_CNT);

    logic [LK_W-1:0] lk_cnt_q, lk_cnt_d;

    // Count quiet tracking transitions; any shift request restarts the count.
    always_comb begin
        lk_cnt_d = lk_cnt_q;
        if (v_clr) begin
            lk_cnt_d = '0;
        end else if (en && din_valid && state_q == TRACK && transition
                     && lk_cnt_q != LK_MAX) begin
            lk_cnt_d = lk_cnt_q + LK_W'(1);
        end
    end

    // Lock counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lk_cnt_q <= '0;
        end else begin
            lk_cnt_q <= lk_cnt_d;
        end
    end

    assign lock = (lk_cnt_q == LK_MAX);
`endif

endmodule

// File: tb/tb_cdr_shift_commander.sv
// Self-checking bench for cdr_shift_commander (CDR_LOCK_DETECT_EN optional).
module tb_cdr_shift_commander;

    logic       clk;
    logic       rst;
    logic       en;
    logic       din_e;
    logic       din_d;
    logic       din_valid;
    logic       sr;
    logic       sl;
    logic [4:0] tap_pos;
    logic       at_limit;
`ifdef CDR_LOCK_DETECT_EN
    logic       lock;
`endif

    int checks   = 0;
    int failures = 0;
    int sr_cnt   = 0;
    int sl_cnt   = 0;
    logic dcur   = 1'b0;
    logic prev_sr = 1'b0;
    logic prev_sl = 1'b0;

    // Reference model state (spec-level: counters and a countdown).
    int  m_vote = 0, m_hold = 0, m_pos = 16, m_lk = 0;
    bit  m_primed = 0, m_dprev = 0, m_sr = 0, m_sl = 0;

    cdr_shift_commander dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din_e     (din_e),
        .din_d     (din_d),
        .din_valid (din_valid),
        .sr        (sr),
        .sl        (sl),
        .tap_pos   (tap_pos),
`ifdef CDR_LOCK_DETECT_EN
        .lock      (lock),
`endif
        .at_limit  (at_limit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: first valid sample primes, transitions vote +1 early / -1 late,
    // |vote| reaching 8 commands a shift (if in range) and 4 holdoff cycles.
    always @(posedge clk or negedge rst) begin : model
        int v, h, p, lk;
        bit pr, dp, s_r, s_l;
        if (!rst) begin
            m_vote <= 0; m_hold <= 0; m_pos <= 16; m_lk <= 0;
            m_primed <= 0; m_dprev <= 0; m_sr <= 0; m_sl <= 0;
        end else begin
            v = m_vote; h = m_hold; p = m_pos; lk = m_lk;
            pr = m_primed; dp = m_dprev; s_r = 0; s_l = 0;
            if (en) begin
                if (h > 0) begin
                    h = h - 1;
                    if (din_valid) dp = din_d;
                end else if (din_valid) begin
                    if (!pr) begin
                        pr = 1;
                    end else if (din_d != dp) begin
                        v = v + ((din_e == dp) ? 1 : -1);
                        if (v > 15) v = 15;
                        if (v < -15) v = -15;
                        if (v >= 8 || v <= -8) begin
                            if (v > 0 && p < 31) begin p = p + 1; s_r = 1; end
                            else if (v < 0 && p > 0) begin p = p - 1; s_l = 1; end
                            v = 0; h = 4; lk = 0;
                        end else if (lk < 64) begin
                            lk = lk + 1;
                        end
                    end
                    dp = din_d;
                end
            end
            m_vote <= v; m_hold <= h; m_pos <= p; m_lk <= lk;
            m_primed <= pr; m_dprev <= dp; m_sr <= s_r; m_sl <= s_l;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("sr", int'(sr), int'(m_sr));
        chk("sl", int'(sl), int'(m_sl));
        chk("tap_pos", int'(tap_pos), m_pos);
        chk("at_limit", int'(at_limit), int'(m_pos == 0 || m_pos == 31));
        chk("sr_sl_both", int'(sr && sl), 0);
        chk("pulse_consec", int'((sr && prev_sr) || (sl && prev_sl)), 0);
`ifdef CDR_LOCK_DETECT_EN
        chk("lock", int'(lock), int'(m_lk >= 64));
`endif
        prev_sr = sr;
        prev_sl = sl;
        if (sr) sr_cnt++;
        if (sl) sl_cnt++;
    end

    task automatic cyc(input logic e_n, input logic v, input logic e, input logic d);
        @(negedge clk);
        en = e_n; din_valid = v; din_e = e; din_d = d;
        if (e_n && v) dcur = d;
    endtask

    task automatic early_step();
        cyc(1'b1, 1'b1, dcur, ~dcur);
    endtask

    task automatic late_step();
        cyc(1'b1, 1'b1, ~dcur, ~dcur);
    endtask

    task automatic frozen_step();
        cyc(1'b0, 1'b1, dcur, ~dcur);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, dcur);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b0; din_valid = 1'b0; din_e = 1'b0; din_d = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        dcur = 1'b0;
        #2;
        sr_cnt = 0;
        sl_cnt = 0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; din_valid = 1'b0; din_e = 1'b0; din_d = 1'b0;

        // Reset state
        do_reset();
        chk("rst_sr", int'(sr), 0);
        chk("rst_sl", int'(sl), 0);
        chk("rst_tap", int'(tap_pos), 16);
        chk("rst_at_limit", int'(at_limit), 0);

        // Early votes with an en=0 gap mid-count, en=0 inside holdoff too
        cyc(1'b1, 1'b1, 1'b0, 1'b1);            // WARM
        repeat (4) early_step();
        repeat (3) frozen_step();
        repeat (4) early_step();
        idle(1);
        #2;
        chk("t1_sr_latency", int'(sr), 1);
        chk("t1_tap", int'(tap_pos), 17);
        early_step();
        repeat (5) frozen_step();
        repeat (2) early_step();
        idle(3);
        #2;
        chk("t1_sr_count", sr_cnt, 1);
        chk("t1_sl_count", sl_cnt, 0);

        // Late votes
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (8) late_step();
        idle(1);
        #2;
        chk("t2_sl_latency", int'(sl), 1);
        chk("t2_tap", int'(tap_pos), 15);
        repeat (4) late_step();
        idle(2);
        #2;
        chk("t2_sl_count", sl_cnt, 1);

        // Balanced votes
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (50) begin early_step(); late_step(); end
        idle(2);
        #2;
        chk("t3_tap", int'(tap_pos), 16);
        chk("t3_pulses", sr_cnt + sl_cnt, 0);

        // Run into the upper limit
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (250) early_step();
        idle(2);
        #2;
        chk("t4_tap", int'(tap_pos), 31);
        chk("t4_at_limit", int'(at_limit), 1);
        chk("t4_sr_count", sr_cnt, 15);

        // Reset lands on the threshold cycle
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (7) early_step();
        @(negedge clk);
        en = 1'b1; din_valid = 1'b1; din_e = dcur; din_d = ~dcur;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b0;
        dcur = 1'b0;
        idle(1);
        #2;
        chk("t5_no_pulse", sr_cnt, 0);
        chk("t5_tap", int'(tap_pos), 16);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);            // must be WARM, not a vote
        repeat (7) early_step();
        idle(1);
        #2;
        chk("t5_warm_no_vote", sr_cnt, 0);
        early_step();
        idle(1);
        #2;
        chk("t5_pulse_after_warm", int'(sr), 1);
        chk("t5_tap_after", int'(tap_pos), 17);

`ifdef CDR_LOCK_DETECT_EN
        // Lock after 64 quiet transitions; a shift clears it
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (31) begin early_step(); late_step(); end
        early_step();
        idle(1);
        #2;
        chk("lk_not_yet", int'(lock), 0);
        late_step();
        idle(1);
        #2;
        chk("lk_set", int'(lock), 1);
        repeat (8) early_step();
        idle(1);
        #2;
        chk("lk_sr", int'(sr), 1);
        chk("lk_cleared", int'(lock), 0);
`endif

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
